// File: rtl/ex_mem_flag_stage.sv
// EX/MEM pipeline register with the architectural NZCV flag register and
// branch resolution for B.cond, CBZ and CBNZ.

module ex_mem_flag_stage #(
  parameter int REGDATASIZE = 64,
  parameter int FLAGSIZE    = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,

  input  logic                   ex_valid,
  output logic                   ex_ready,
  input  logic [REGDATASIZE-1:0] ex_result,
  input  logic [FLAGSIZE-1:0]    ex_flags,
  input  logic                   ex_set_flags,
  input  logic                   ex_is_bcond,
  input  logic [3:0]             ex_cond,
  input  logic                   ex_is_cbz,
  input  logic                   ex_is_cbnz,
  input  logic [REGDATASIZE-1:0] ex_target,

  input  logic                   flush,
  input  logic                   mem_ready,

  output logic                   mem_valid,
  output logic [REGDATASIZE-1:0] mem_result,
  output logic                   mem_branch_taken,
  output logic [REGDATASIZE-1:0] mem_target,
  output logic [FLAGSIZE-1:0]    nzcv
);

  // Bit positions inside the flag vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_HS = 4'h2, COND_LO = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  function automatic logic cond_holds(input logic [FLAGSIZE-1:0] flags,
                                      input logic [3:0]          cond);
    logic n, z, c, v, ok;
    n  = flags[FLAG_N];
    z  = flags[FLAG_Z];
    c  = flags[FLAG_C];
    v  = flags[FLAG_V];
    ok = 1'b0;
    case (cond_e'(cond))
      COND_EQ: ok = z;
      COND_NE: ok = !z;
      COND_HS: ok = c;
      COND_LO: ok = !c;
      COND_MI: ok = n;
      COND_PL: ok = !n;
      COND_VS: ok = v;
      COND_VC: ok = !v;
      COND_HI: ok = c && !z;
      COND_LS: ok = !c || z;
      COND_GE: ok = (n == v);
      COND_LT: ok = (n != v);
      COND_GT: ok = !z && (n == v);
      COND_LE: ok = z || (n != v);
      COND_AL, COND_NV: ok = 1'b1;
    endcase
    return ok;
  endfunction

  logic accept;
  logic result_zero;
  logic cond_true;
  logic multi_branch;
  logic branch_taken;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    ex_ready     = 1'b0;
    accept       = 1'b0;
    result_zero  = 1'b0;
    cond_true    = 1'b0;
    multi_branch = 1'b0;
    branch_taken = 1'b0;

    ex_ready    = !mem_valid || mem_ready;
    accept      = ex_valid && ex_ready && !flush;
    result_zero = (ex_result == '0);

    // B.cond reads the committed flags, never the flags of the instruction
    // travelling alongside it.
    cond_true = cond_holds(nzcv, ex_cond);

    // A malformed instruction claiming two branch kinds is never taken.
    multi_branch = (ex_is_bcond && ex_is_cbz) ||
                   (ex_is_bcond && ex_is_cbnz) ||
                   (ex_is_cbz   && ex_is_cbnz);

    if (!multi_branch) begin
      branch_taken = (ex_is_bcond && cond_true)    ||
                     (ex_is_cbz   && result_zero)  ||
                     (ex_is_cbnz  && !result_zero);
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the data registers are reset too, so MEM outputs read as zero
      // straight out of reset rather than as leftover values.
      mem_valid        <= 1'b0;
      mem_result       <= '0;
      mem_target       <= '0;
      mem_branch_taken <= 1'b0;
      nzcv             <= '0;
    end else if (flush) begin
      mem_valid <= 1'b0;
    end else if (accept) begin
      mem_valid        <= 1'b1;
      mem_result       <= ex_result;
      mem_target       <= ex_target;
      mem_branch_taken <= branch_taken;
      if (ex_set_flags) begin
        nzcv <= ex_flags;
      end
    end else if (mem_ready) begin
      mem_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Bench for ex_mem_flag_stage: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the stage.

module tb_ex_mem_flag_stage;

  logic        clk;
  logic        reset_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [63:0] ex_result;
  logic [3:0]  ex_flags;
  logic        ex_set_flags;
  logic        ex_is_bcond;
  logic [3:0]  ex_cond;
  logic        ex_is_cbz;
  logic        ex_is_cbnz;
  logic [63:0] ex_target;
  logic        flush;
  logic        mem_ready;
  logic        mem_valid;
  logic [63:0] mem_result;
  logic        mem_branch_taken;
  logic [63:0] mem_target;
  logic [3:0]  nzcv;

  ex_mem_flag_stage #(.REGDATASIZE(64), .FLAGSIZE(4)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .ex_valid         (ex_valid),
    .ex_ready         (ex_ready),
    .ex_result        (ex_result),
    .ex_flags         (ex_flags),
    .ex_set_flags     (ex_set_flags),
    .ex_is_bcond      (ex_is_bcond),
    .ex_cond          (ex_cond),
    .ex_is_cbz        (ex_is_cbz),
    .ex_is_cbnz       (ex_is_cbnz),
    .ex_target        (ex_target),
    .flush            (flush),
    .mem_ready        (mem_ready),
    .mem_valid        (mem_valid),
    .mem_result       (mem_result),
    .mem_branch_taken (mem_branch_taken),
    .mem_target       (mem_target),
    .nzcv             (nzcv)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests_run = 0;
  int tests_failed = 0;

  // Reference state: what the MEM slot and flag register should contain.
  logic        m_valid;
  logic [63:0] m_result;
  logic [63:0] m_target;
  logic        m_taken;
  logic [3:0]  m_nzcv;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Condition rules written out from the ARM definitions; flags = {N,Z,C,V}.
  function automatic logic ref_cond(input logic [3:0] f, input int cc);
    bit n = f[3], z = f[2], c = f[1], v = f[0];
    if (cc == 0)  return z;
    if (cc == 1)  return !z;
    if (cc == 2)  return c;
    if (cc == 3)  return !c;
    if (cc == 4)  return n;
    if (cc == 5)  return !n;
    if (cc == 6)  return v;
    if (cc == 7)  return !v;
    if (cc == 8)  return c && !z;
    if (cc == 9)  return !c || z;
    if (cc == 10) return n == v;
    if (cc == 11) return n != v;
    if (cc == 12) return !z && (n == v);
    if (cc == 13) return z || (n != v);
    return 1'b1;
  endfunction

  function automatic logic ref_taken(input logic [3:0] flags);
    int kinds = int'(ex_is_bcond) + int'(ex_is_cbz) + int'(ex_is_cbnz);
    if (kinds != 1) return 1'b0;
    if (ex_is_bcond) return ref_cond(flags, int'(ex_cond));
    if (ex_is_cbz)   return ex_result == 64'd0;
    return ex_result != 64'd0;
  endfunction

  // One clock: check ready, advance the model at the edge, check outputs.
  task automatic tick();
    logic exp_ready, take, tk;
    @(negedge clk);
    exp_ready = !m_valid || mem_ready;
    check("ex_ready", ex_ready, exp_ready);
    take = ex_valid && exp_ready && !flush;
    tk   = ref_taken(m_nzcv);
    @(posedge clk);
    if (!reset_n) begin
      m_valid = 0; m_result = 0; m_target = 0; m_taken = 0; m_nzcv = 0;
    end else if (flush) begin
      m_valid = 0;
    end else if (take) begin
      m_valid  = 1;
      m_result = ex_result;
      m_target = ex_target;
      m_taken  = tk;
      if (ex_set_flags) m_nzcv = ex_flags;
    end else if (mem_ready) begin
      m_valid = 0;
    end
    #1;
    check("mem_valid", mem_valid, m_valid);
    check("nzcv", nzcv, m_nzcv);
    if (m_valid) begin
      check("mem_result", mem_result, m_result);
      check("mem_target", mem_target, m_target);
      check("mem_branch_taken", mem_branch_taken, m_taken);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] res, input logic [3:0] fl,
                       input logic sf, input logic bc, input logic [3:0] cc,
                       input logic z, input logic nz, input logic [63:0] tgt);
    ex_valid = v; ex_result = res; ex_flags = fl; ex_set_flags = sf;
    ex_is_bcond = bc; ex_cond = cc; ex_is_cbz = z; ex_is_cbnz = nz; ex_target = tgt;
  endtask

  task automatic do_reset();
    reset_n = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("rst_mem_valid", mem_valid, 1'b0);
    check("rst_result", mem_result, 64'd0);
    check("rst_target", mem_target, 64'd0);
    check("rst_taken", mem_branch_taken, 1'b0);
    check("rst_nzcv", nzcv, 4'd0);
    reset_n = 1;
    check("ready_after_rst", ex_ready, 1'b1);
  endtask

  initial begin
    m_valid = 0; m_result = 0; m_target = 0; m_taken = 0; m_nzcv = 0;
    flush = 0; mem_ready = 1;
    do_reset();

    // SUBS setting Z, then B.EQ on the following cycle.
    drive(1, 64'h0, 4'b0100, 1, 0, 0, 0, 0, 64'h10);
    tick();
    drive(1, 64'h33, 4'b0000, 0, 1, 4'h0, 0, 0, 64'h200);
    tick();
    check("beq_nzcv", nzcv, 4'b0100);
    check("beq_taken", mem_branch_taken, 1'b1);
    check("beq_target", mem_target, 64'h200);

    // SUBS (N=1,V=0) then B.GT back to back from nzcv=0000.
    do_reset();
    drive(1, 64'h8, 4'b1000, 1, 0, 0, 0, 0, 64'h0);
    tick();
    drive(1, 64'h9, 4'b0000, 0, 1, 4'hC, 0, 0, 64'h300);
    tick();
    check("bgt_nzcv", nzcv, 4'b1000);
    check("bgt_taken", mem_branch_taken, 1'b0);

    // CBZ / CBNZ.
    drive(1, 64'd0, 0, 0, 0, 0, 1, 0, 64'h40);
    tick();
    check("cbz0_taken", mem_branch_taken, 1'b1);
    drive(1, 64'd5, 0, 0, 0, 0, 0, 1, 64'h44);
    tick();
    check("cbnz5_taken", mem_branch_taken, 1'b1);
    drive(1, 64'd5, 0, 0, 0, 0, 1, 0, 64'h48);
    tick();
    check("cbz5_taken", mem_branch_taken, 1'b0);

    // Three-cycle stall with a flag-setting instruction waiting in EX.
    drive(1, 64'h1234, 0, 0, 0, 0, 0, 1, 64'hBEEF);
    tick();
    mem_ready = 0;
    drive(1, 64'd0, 4'b1111, 1, 0, 0, 0, 0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_ready", ex_ready, 1'b0);
      check("stall_valid", mem_valid, 1'b1);
      check("stall_result", mem_result, 64'h1234);
      check("stall_target", mem_target, 64'hBEEF);
      check("stall_taken", mem_branch_taken, 1'b1);
      check("stall_nzcv", nzcv, 4'b1000);
    end
    mem_ready = 1;
    tick();
    check("post_stall_nzcv", nzcv, 4'b1111);

    // Flush squashes a flag-setting instruction and the MEM slot.
    flush = 1;
    drive(1, 64'd1, 4'b0000, 1, 0, 0, 0, 0, 64'h0);
    tick();
    check("flush_valid", mem_valid, 1'b0);
    check("flush_nzcv", nzcv, 4'b1111);
    flush = 0;

    // Reset in the middle of a stall.
    drive(1, 64'd7, 0, 0, 0, 0, 0, 0, 64'h70);
    tick();
    mem_ready = 0;
    tick();
    check("pre_rst_valid", mem_valid, 1'b1);
    do_reset();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      int kind;
      logic [63:0] res;
      reset_n   = ($urandom_range(0, 59) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      mem_ready = ($urandom_range(0, 9) < 7);
      res  = ($urandom_range(0, 3) == 0) ? 64'd0 : {32'($urandom), 32'($urandom)};
      kind = $urandom_range(0, 5);
      drive($urandom_range(0, 3) != 0, res, 4'($urandom), 1'($urandom),
            kind == 1 || kind == 4, 4'($urandom),
            kind == 2 || kind == 4 || kind == 5, kind == 3 || kind == 5,
            {32'($urandom), 32'($urandom)});
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
